// File: rtl/dropout_lfsr_array.sv
// Multi-lane Bernoulli dropout stage with a shared Galois LFSR, valid/ready output register and dropped-lane counter.
// Optional inverted-dropout scaling of kept lanes is built when DROPOUT_SCALE_EN is defined.
module dropout_lfsr_array #(
  parameter int unsigned       WIDTH    = 8,
  parameter int unsigned       CHANNELS = 8,
  parameter int unsigned       LFSR_W   = 16,
  parameter logic [LFSR_W-1:0] TAPS     = LFSR_W'(16'hB400),
  parameter logic [LFSR_W-1:0] SEED     = LFSR_W'(16'hACE1),
  parameter int unsigned       PROB_W   = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      ena,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic                      train_mode,
  input  logic [PROB_W-1:0]         drop_thresh,
  input  logic [1:0]                scale_shift,
  input  logic                      seed_load,
  input  logic [LFSR_W-1:0]         seed_value,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [CHANNELS*WIDTH-1:0] out_data,
  output logic [CHANNELS-1:0]       out_mask,
  output logic [15:0]               drop_count
);

  localparam int unsigned DATA_W = CHANNELS * WIDTH;
  localparam int unsigned CNT_W  = 16;
  localparam int unsigned SUM_W  = CNT_W + 1;
  localparam int unsigned POP_W  = $clog2(CHANNELS + 1);

  logic [LFSR_W-1:0] lfsr;
  logic [LFSR_W-1:0] lfsr_step;
  logic [LFSR_W-1:0] lfsr_seed;
  logic [CHANNELS-1:0] keep;
  logic [DATA_W-1:0]   next_data;
  logic [POP_W-1:0]    drops;
  logic [SUM_W-1:0]    cnt_sum;
  logic [CNT_W-1:0]    cnt_next;
  logic                accept;

  assign in_ready  = ena & (~out_valid | out_ready);
  assign accept    = in_valid & in_ready;
  assign lfsr_step = (lfsr >> 1) ^ (lfsr[0] ? TAPS : '0);
  assign lfsr_seed = (seed_value == '0) ? SEED : seed_value;

  // Per-lane random value is a fixed rotation of the shared state, so lanes see decorrelated bits.
  for (genvar c = 0; c < CHANNELS; c++) begin : g_lane
    localparam int unsigned SH = (2 * c) % LFSR_W;
    logic [PROB_W-1:0] r;
    logic [WIDTH-1:0]  lane_in;
    logic [WIDTH-1:0]  kept;

    for (genvar i = 0; i < PROB_W; i++) begin : g_r
      assign r[i] = lfsr[(i + LFSR_W - SH) % LFSR_W];
    end

    assign lane_in = in_data[c*WIDTH +: WIDTH];
    assign keep[c] = ~train_mode | (r >= drop_thresh);

`ifdef DROPOUT_SCALE_EN
    logic [WIDTH+2:0] shifted;
    assign shifted = {3'b000, lane_in} << scale_shift;
    assign kept = !train_mode ? lane_in :
                  (|shifted[WIDTH+2:WIDTH]) ? {WIDTH{1'b1}} : shifted[WIDTH-1:0];
`else
    assign kept = lane_in;
`endif

    assign next_data[c*WIDTH +: WIDTH] = keep[c] ? kept : '0;
  end

`ifndef DROPOUT_SCALE_EN
  logic unused_scale;
  assign unused_scale = ^scale_shift;
`endif

  // Saturating add of this beat's dropped-lane count.
  always_comb begin
    drops = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      drops = drops + POP_W'(!keep[i]);
    end
    cnt_sum  = {1'b0, drop_count} + SUM_W'(drops);
    cnt_next = cnt_sum[CNT_W] ? {CNT_W{1'b1}} : cnt_sum[CNT_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lfsr       <= SEED;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_mask   <= '0;
      drop_count <= '0;
    end else if (ena) begin
      // A same-cycle seed load overrides the step; the accepted beat already used the old state.
      if (seed_load) begin
        lfsr <= lfsr_seed;
      end else if (accept && train_mode) begin
        lfsr <= lfsr_step;
      end

      if (accept) begin
        out_valid  <= 1'b1;
        out_data   <= next_data;
        out_mask   <= keep;
        drop_count <= cnt_next;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_dropout_lfsr_array.sv
// Scoreboard bench for dropout_lfsr_array: a driver queues expected beats, a monitor checks them on drain.
module tb_dropout_lfsr_array;

  localparam logic [15:0] SEED = 16'hACE1;
  localparam logic [15:0] TAPS = 16'hB400;
  localparam logic [63:0] RAMP = 64'h0807060504030201;

  typedef struct packed {
    logic [63:0] data;
    logic [7:0]  mask;
    logic [15:0] cnt;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ena;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_data;
  logic        train_mode;
  logic [7:0]  drop_thresh;
  logic [1:0]  scale_shift;
  logic        seed_load;
  logic [15:0] seed_value;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_data;
  logic [7:0]  out_mask;
  logic [15:0] drop_count;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  logic [15:0] m_lfsr;
  logic [15:0] m_cnt;

  dropout_lfsr_array dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .train_mode(train_mode), .drop_thresh(drop_thresh),
    .scale_shift(scale_shift), .seed_load(seed_load), .seed_value(seed_value),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_mask(out_mask), .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] model_r(input logic [15:0] s, input int c);
    logic [31:0] dbl;
    logic [31:0] t;
    int sh;
    dbl = {s, s};
    sh  = (2 * c) % 16;
    t   = dbl >> (16 - sh);
    return t[7:0];
  endfunction

  function automatic logic [7:0] model_keep_val(input logic [7:0] lane, input bit tr);
`ifdef DROPOUT_SCALE_EN
    int v;
    if (!tr) return lane;
    v = int'(lane) << scale_shift;
    return (v > 255) ? 8'hFF : v[7:0];
`else
    if (tr) return lane;
    return lane;
`endif
  endfunction

  task automatic model_beat(input logic [63:0] d, input logic [7:0] th, input bit tr, output exp_t e);
    int drops;
    int sum;
    logic [7:0] r;
    drops = 0;
    e = '0;
    for (int c = 0; c < 8; c++) begin
      r = model_r(m_lfsr, c);
      if (!tr || r >= th) begin
        e.mask[c] = 1'b1;
        e.data[c*8 +: 8] = model_keep_val(d[c*8 +: 8], tr);
      end else begin
        drops++;
      end
    end
    sum   = int'(m_cnt) + drops;
    m_cnt = (sum > 65535) ? 16'hFFFF : 16'(sum);
    e.cnt = m_cnt;
    if (tr) m_lfsr = m_lfsr[0] ? ((m_lfsr >> 1) ^ TAPS) : (m_lfsr >> 1);
  endtask

  // Present one beat until accepted; queue either the model or a hand-computed expectation.
  task automatic send_beat(input logic [63:0] d, input logic [7:0] th, input bit tr,
                           input bit use_hand, input exp_t hand_e,
                           input bit do_load, input logic [15:0] load_val);
    exp_t e;
    int   waited;
    bit   done;
    in_data     = d;
    drop_thresh = th;
    train_mode  = tr;
    in_valid    = 1'b1;
    seed_load   = do_load;
    seed_value  = load_val;
    waited      = 0;
    done        = 0;
    while (!done) begin
      @(negedge clk);
      if (in_ready === 1'b1) begin
        done = 1;
        model_beat(d, th, tr, e);
        if (do_load) m_lfsr = (load_val == 16'h0) ? SEED : load_val;
        sb.push_back(use_hand ? hand_e : e);
      end else begin
        waited++;
        if (waited > 50) begin
          checks++;
          errors++;
          $display("FAIL accept_timeout: got in_ready=%b expected 1", in_ready);
          done = 1;
        end
      end
      @(posedge clk);
      #1;
    end
    in_valid  = 1'b0;
    seed_load = 1'b0;
  endtask

  task automatic beat(input logic [63:0] d, input logic [7:0] th, input bit tr);
    send_beat(d, th, tr, 1'b0, '0, 1'b0, 16'h0);
  endtask

  task automatic hand_beat(input logic [63:0] d, input logic [7:0] th, input bit tr,
                           input logic [63:0] xd, input logic [7:0] xm, input logic [15:0] xc);
    exp_t h;
    h.data = xd;
    h.mask = xm;
    h.cnt  = xc;
    send_beat(d, th, tr, 1'b1, h, 1'b0, 16'h0);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    in_valid = 1'b0;
    idle(2);
    rst_n  = 1'b1;
    sb.delete();
    m_lfsr = SEED;
    m_cnt  = 16'h0;
  endtask

  // Monitor: a beat is consumed at the next rising edge when valid and ready are both high.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_beat: got out_data=%h expected no beat", out_data);
        end else begin
          e = sb.pop_front();
          check("beat_data", out_data, e.data);
          check("beat_mask", 64'(out_mask), 64'(e.mask));
          check("beat_count", 64'(drop_count), 64'(e.cnt));
        end
      end
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: got no finish expected finish before 2ms");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; ena = 1'b1; in_valid = 1'b0; in_data = '0; train_mode = 1'b1;
    drop_thresh = '0; scale_shift = 2'd0; seed_load = 1'b0; seed_value = '0; out_ready = 1'b1;
    m_lfsr = SEED; m_cnt = '0;
    @(posedge clk);
    #1;
    do_reset();
    check("reset_valid", 64'(out_valid), 64'd0);
    check("reset_data", out_data, 64'd0);
    check("reset_mask", 64'(out_mask), 64'd0);
    check("reset_count", 64'(drop_count), 64'd0);

    // Threshold 0 never drops.
    hand_beat(RAMP, 8'd0, 1'b1, RAMP, 8'hFF, 16'd0);
    idle(2);

    // From seed 0xACE1 every lane value is below 226; next state 0xE270 drops lanes 0,2,3,6 at 0x71.
    do_reset();
    hand_beat(RAMP, 8'd226, 1'b1, 64'h0, 8'h00, 16'd8);
    hand_beat(RAMP, 8'h71, 1'b1, 64'h0800060500000200, 8'hB2, 16'd12);
    idle(2);

    // Threshold equal to a lane value keeps that lane.
    do_reset();
    hand_beat(RAMP, 8'd134, 1'b1, 64'h0007060500000201, 8'h73, 16'd3);
    idle(2);

    // Backpressure: first beat held stable, second beat refused.
    out_ready = 1'b0;
    beat(64'h1122334455667788, 8'h80, 1'b1);
    in_valid = 1'b1;
    in_data  = 64'hDEADBEEFCAFEF00D;
    repeat (5) begin
      @(negedge clk);
      check("bp_in_ready", 64'(in_ready), 64'd0);
      check("bp_valid", 64'(out_valid), 64'd1);
      check("bp_data", out_data, sb[0].data);
      check("bp_mask", 64'(out_mask), 64'(sb[0].mask));
      @(posedge clk);
      #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    idle(2);
    beat(64'hA5A5A5A5A5A5A5A5, 8'h80, 1'b1);
    beat(64'h0F0F0F0F0F0F0F0F, 8'h40, 1'b1);
    idle(2);

    // Disabled block refuses beats and keeps its LFSR.
    ena      = 1'b0;
    in_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("ena_in_ready", 64'(in_ready), 64'd0);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    ena      = 1'b1;
    beat(64'h123456789ABCDEF0, 8'hC0, 1'b1);
    idle(2);

    // Zero seed falls back to SEED; inference beats pass through without advancing.
    seed_load  = 1'b1;
    seed_value = 16'h0;
    idle(1);
    seed_load = 1'b0;
    m_lfsr    = SEED;
    hand_beat(64'hFFEEDDCCBBAA9988, 8'hFF, 1'b0, 64'hFFEEDDCCBBAA9988, 8'hFF, m_cnt);
    hand_beat(RAMP, 8'hFF, 1'b0, RAMP, 8'hFF, m_cnt);
    hand_beat(RAMP, 8'd134, 1'b1, 64'h0007060500000201, 8'h73, m_cnt + 16'd3);

    // Seed load in the accept cycle: the beat uses the old state, the next beat the new one.
    send_beat(RAMP, 8'h90, 1'b1, 1'b0, '0, 1'b1, 16'h1234);
    beat(RAMP, 8'h90, 1'b1);
    idle(2);

    // Reset discards a held beat.
    out_ready = 1'b0;
    beat(RAMP, 8'h10, 1'b1);
    do_reset();
    check("reset_discard_valid", 64'(out_valid), 64'd0);
    out_ready = 1'b1;
    idle(1);

`ifdef DROPOUT_SCALE_EN
    scale_shift = 2'd1;
    hand_beat(64'h0101010101019040, 8'd0, 1'b1, 64'h020202020202FF80, 8'hFF, 16'd0);
    idle(2);
    scale_shift = 2'd0;
`endif

    // Counter saturation over a long all-drop run.
    do_reset();
    for (int i = 0; i < 9000; i++) begin
      beat({8{8'(i)}}, 8'hFF, 1'b1);
    end
    idle(3);
    check("count_saturated", 64'(drop_count), 64'hFFFF);
    check("queue_drained", 64'(sb.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
